// File: rtl/msx_slot_bus_master_if.sv
// Host request port and MSX cartridge slot bus signals of msx_slot_bus_master.
// The master modport is the initiator view; slave is the host/responder view.
interface msx_slot_bus_master_if;
  logic        i_REQ;
  logic        i_WE;
  logic [15:0] i_ADDR;
  logic [7:0]  i_WDATA;
  logic        o_ACK;
  logic        o_BUSY;
  logic [7:0]  o_RDATA;
  logic        o_RVALID;
  logic        o_CS_n;
  logic        o_RD_n;
  logic        o_WR_n;
  logic [15:0] o_AB;
  logic [7:0]  o_DB;
  logic        o_DB_OE;
  logic [7:0]  i_DB;
  logic        i_WAIT_n;

  modport master (
    input  i_REQ, i_WE, i_ADDR, i_WDATA, i_DB, i_WAIT_n,
    output o_ACK, o_BUSY, o_RDATA, o_RVALID, o_CS_n, o_RD_n, o_WR_n,
           o_AB, o_DB, o_DB_OE
  );

  modport slave (
    output i_REQ, i_WE, i_ADDR, i_WDATA, i_DB, i_WAIT_n,
    input  o_ACK, o_BUSY, o_RDATA, o_RVALID, o_CS_n, o_RD_n, o_WR_n,
           o_AB, o_DB, o_DB_OE
  );
endinterface

// File: rtl/msx_slot_bus_master.sv
// MSX slot bus initiator: single host requests become /CS-/RD-/WR memory cycles timed in phiM ticks.
// Slot /WAIT support (TW state) is built only when MSX_SLOT_BUS_MASTER_WAIT_EN is defined.
module msx_slot_bus_master #(
  parameter int unsigned RECOVERY_TICKS = 1,
  parameter int unsigned WR_DELAY_TICKS = 1
) (
  input  logic                  i_EMUCLK,
  input  logic                  i_RST_n,
  input  logic                  i_MCLK_PCEN_n,
  msx_slot_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
    ST_TW   = 3'd3,
`endif
    ST_T3   = 3'd4,
    ST_REC  = 3'd5
  } state_e;

  localparam logic [1:0] REC_LAST = (RECOVERY_TICKS > 32'd0) ? 2'(RECOVERY_TICKS - 32'd1) : 2'd0;
  localparam logic       REC_SKIP = (RECOVERY_TICKS == 32'd0);
  localparam logic       WR_EARLY = (WR_DELAY_TICKS == 32'd1);

  state_e      state_q, state_d;
  logic [1:0]  rec_cnt_q, rec_cnt_d;
  logic        we_q, we_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [15:0] ab_q, ab_d;
  logic [7:0]  db_q, db_d;
  logic        db_oe_q, db_oe_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        tick_s;

  assign tick_s = ~i_MCLK_PCEN_n;

`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
  logic [1:0] wait_sync_q, wait_sync_d;
  logic       wait_ok_s;

  assign wait_sync_d = {wait_sync_q[0], bus.i_WAIT_n};
  assign wait_ok_s   = wait_sync_q[1];

  // /WAIT is asynchronous to EMUCLK; resets to "not waiting".
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wait_sync_q <= 2'b11;
    end else begin
      wait_sync_q <= wait_sync_d;
    end
  end
`else
  logic unused_wait_s;
  assign unused_wait_s = bus.i_WAIT_n;
`endif

  // State and recovery counter registers.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q   <= ST_IDLE;
      rec_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  // Next-state logic; the FSM only moves on phiM enable ticks.
  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_REQ) begin
            state_d = ST_T1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_T1: state_d = ST_T2;
        ST_T2: begin
`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
          state_d = wait_ok_s ? ST_T3 : ST_TW;
`else
          state_d = ST_T3;
`endif
        end
`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
        ST_TW: begin
          if (wait_ok_s) begin
            state_d = ST_T3;
          end else begin
            state_d = ST_TW;
          end
        end
`endif
        ST_T3: begin
          rec_cnt_d = 2'd0;
          state_d   = REC_SKIP ? ST_IDLE : ST_REC;
        end
        ST_REC: begin
          if (rec_cnt_q == REC_LAST) begin
            state_d = ST_IDLE;
          end else begin
            rec_cnt_d = rec_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rec_cnt_d = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: next values of every registered bus and host output.
  always_comb begin
    we_d     = we_q;
    cs_n_d   = cs_n_q;
    rd_n_d   = rd_n_q;
    wr_n_d   = wr_n_q;
    ab_d     = ab_q;
    db_d     = db_q;
    db_oe_d  = db_oe_q;
    busy_d   = busy_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    rvalid_d = 1'b0;
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_REQ) begin
            we_d    = bus.i_WE;
            ab_d    = bus.i_ADDR;
            cs_n_d  = 1'b0;
            rd_n_d  = bus.i_WE;
            ack_d   = 1'b1;
            busy_d  = 1'b1;
            db_oe_d = bus.i_WE;
            if (bus.i_WE) begin
              db_d = bus.i_WDATA;
            end else begin
              db_d = db_q;
            end
          end else begin
            // End of the write data hold tick when recovery is zero.
            db_oe_d = 1'b0;
          end
        end
        ST_T1: begin
          if (we_q && WR_EARLY) begin
            wr_n_d = 1'b0;
          end else begin
            wr_n_d = wr_n_q;
          end
        end
        ST_T2: begin
          if (we_q && !WR_EARLY) begin
            wr_n_d = 1'b0;
          end else begin
            wr_n_d = wr_n_q;
          end
        end
`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
        ST_TW: busy_d = busy_q;
`endif
        ST_T3: begin
          cs_n_d = 1'b1;
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          if (!we_q) begin
            rdata_d  = bus.i_DB;
            rvalid_d = 1'b1;
          end else begin
            rdata_d = rdata_q;
          end
          if (REC_SKIP) begin
            busy_d = 1'b0;
          end else begin
            busy_d = busy_q;
          end
        end
        ST_REC: begin
          db_oe_d = 1'b0;
          if (rec_cnt_q == REC_LAST) begin
            busy_d = 1'b0;
          end else begin
            busy_d = busy_q;
          end
        end
        default: begin
          cs_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          db_oe_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      ack_d = 1'b0;
    end
  end

  // Output registers; reset releases every strobe immediately.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      we_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ab_q     <= 16'h0000;
      db_q     <= 8'h00;
      db_oe_q  <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      we_q     <= we_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ab_q     <= ab_d;
      db_q     <= db_d;
      db_oe_q  <= db_oe_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.o_ACK    = ack_q;
  assign bus.o_BUSY   = busy_q;
  assign bus.o_RDATA  = rdata_q;
  assign bus.o_RVALID = rvalid_q;
  assign bus.o_CS_n   = cs_n_q;
  assign bus.o_RD_n   = rd_n_q;
  assign bus.o_WR_n   = wr_n_q;
  assign bus.o_AB     = ab_q;
  assign bus.o_DB     = db_q;
  assign bus.o_DB_OE  = db_oe_q;

endmodule

// File: doc/msx_slot_bus_master.md
Name: msx_slot_bus_master

Overview:
- Initiator side of the MSX cartridge slot bus: turns single read/write requests from an internal host port into Z80-style memory cycles on /CS, /RD, /WR, AB[15:0] and DB[7:0].
- Drives SCC-type cartridge responders in the tnCart system and their bench models.
- All bus timing is counted in phiM clock-enable ticks on the emulator clock, so the cycles match what a responder with a phiM-synchronised control chain expects.

Parameters:
- RECOVERY_TICKS, 1, idle phiM ticks with all strobes high after each cycle, before IDLE is re-entered (0..3).
- WR_DELAY_TICKS, 1, ticks from /CS fall to /WR fall on writes (1..2); /RD always falls with /CS.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_RST_n  in  1  asynchronous active-low reset
- i_MCLK_PCEN_n  in  1  phiM positive-edge clock enable, negative logic; the FSM advances only on ticks where this is 0
- i_REQ  in  1  host request; the host holds it until o_ACK
- i_WE  in  1  1 = write, 0 = read; sampled at acceptance
- i_ADDR  in  16  cycle address; sampled at acceptance
- i_WDATA  in  8  write data; sampled at acceptance
- o_ACK  out  1  one-EMUCLK pulse on the acceptance tick
- o_BUSY  out  1  high from acceptance until IDLE is re-entered
- o_RDATA  out  8  captured read data; holds until the next read completes
- o_RVALID  out  1  one-EMUCLK pulse when o_RDATA updates
- o_CS_n, o_RD_n, o_WR_n  out  1 each  slot bus strobes
- o_AB  out  16  bus address
- o_DB  out  8  write data
- o_DB_OE  out  1  write data driver enable
- i_DB  in  8  bus read data
- i_WAIT_n  in  1  slot /WAIT; see Optional Feature

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - o_CS_n = o_RD_n = o_WR_n = 1.
  - o_ACK = o_RVALID = o_BUSY = o_DB_OE = 0.
  - o_AB = 0, o_DB = 0, o_RDATA = 0.
  - State = IDLE.
  - A reset mid-cycle releases all strobes at once and discards the cycle, with no o_RVALID.
- States: IDLE, T1, T2, TW, T3, REC. Transitions occur only on enabled ticks, and every output is registered.
- IDLE: on an enabled tick with i_REQ = 1 (call it tick k):
  - latch i_WE, i_ADDR and i_WDATA; pulse o_ACK; set o_BUSY = 1; o_AB = address; o_CS_n = 0; go to T1.
  - Read: o_RD_n = 0 at tick k.
  - Write: o_DB = data and o_DB_OE = 1 at tick k.
  - i_REQ = 0, or i_REQ arriving on a non-enabled EMUCLK cycle, has no effect.
- T1 -> T2 at tick k+1. Write with WR_DELAY_TICKS = 1: o_WR_n = 0 at k+1.
- T2 -> T3 at tick k+2 (to TW instead under the Optional Feature). Write with WR_DELAY_TICKS = 2: o_WR_n = 0 at k+2.
- T3, ending at tick k+3:
  - Read: o_RDATA <= i_DB sampled on that tick; pulse o_RVALID.
  - All cycles: o_CS_n = o_RD_n = o_WR_n = 1.
  - Go to REC, or to IDLE when RECOVERY_TICKS = 0.
- o_DB_OE and o_DB hold through tick k+3 and o_DB_OE clears on the following enabled tick, giving one tick of data hold after the /WR rise.
  - Exception: if that tick accepts a new write, o_DB_OE stays 1 and o_DB takes the new data.
- REC: counts RECOVERY_TICKS enabled ticks, then IDLE; o_BUSY = 0 on IDLE entry.
- Earliest next acceptance is the enabled tick after IDLE entry.
  - Read-to-read spacing is 4 + RECOVERY_TICKS ticks.
  - Read cycles only: /CS and /RD are low for exactly 3 ticks.
- i_REQ held high while o_BUSY = 1 is ignored until IDLE; a request is never lost or duplicated.
- o_AB holds its value after the cycle until the next acceptance.

Optional Feature:
- Macro: MSX_SLOT_BUS_MASTER_WAIT_EN.
- Enabled:
  - i_WAIT_n passes through a 2-flop EMUCLK synchroniser.
  - At the T2 exit tick, if the synced value is 0, the FSM enters TW instead of T3.
  - It stays in TW on every enabled tick while the synced value is 0 and moves to T3 on the first tick it reads 1.
  - Strobes, o_AB and o_DB hold throughout TW, and the read sample point moves accordingly.
- Disabled: i_WAIT_n is ignored, the TW state is not built, and cycle length is fixed.

Test Plan:
1. Read, RECOVERY_TICKS = 1: REQ, WE = 0, ADDR = 0x9800, responder drives DB = 0x5A. Required:
   - /CS and /RD low for ticks k..k+2; o_RDATA = 0x5A with o_RVALID pulsed at k+3.
   - o_BUSY falls at k+4; no /WR activity.
2. Write, WR_DELAY_TICKS = 1: ADDR = 0x9000, WDATA = 0x3F. Required:
   - /WR low at k+1..k+2; o_DB = 0x3F with OE = 1 through k+3; OE = 0 at k+4.
   - An attached SCC-type responder captures bank register 0x3F.
3. Back-to-back: REQ held high for two reads. Required: the second o_ACK comes exactly 5 ticks after the first; exactly two o_RVALID pulses.
4. Reset asserted at tick k+1 of a write. Required: /CS = /WR = 1 and OE = 0 asynchronously, no o_RVALID; after release, IDLE, and a new REQ is accepted normally.
5. With MSX_SLOT_BUS_MASTER_WAIT_EN, i_WAIT_n low for 3 ticks spanning T2. Required: 3 TW ticks; read data sampled 3 ticks later (k+6) and /CS low 6 ticks. Without the macro, cycle length stays 3 ticks.
6. Gating check: i_MCLK_PCEN_n held high for 50 EMUCLK cycles mid-read. Required: no state or strobe change during that window; the cycle resumes exactly where it stopped.
